// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the DMEM load/store initiator:
//   - FSM state encodings (IDLE, RD, WR, RESP)
//   - RV32I load/store funct3 encodings
//   - lane helpers: byte select, load extract/extend, store merge, and the
//     alignment/legality check for a request
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  // Load result: select lane(s) from the word, then sign- or zero-extend.
  function automatic logic [31:0] lane_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = byte_sel(w, lane);
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = w;
      F3_BU:   r = {24'd0, b};
      F3_HU:   r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Sub-word store: overwrite only the addressed lane(s) of the old word.
  function automatic logic [31:0] lane_merge(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] old, input logic [15:0] wd);
    logic [31:0] r;
    r = old;
    case (f3)
      F3_B: begin
        case (lane)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          2'd3:    r[31:24] = wd[7:0];
          default: r = old;
        endcase
      end
      F3_H: begin
        r[31:16] = lane[1] ? wd        : old[31:16];
        r[15:0]  = lane[1] ? old[15:0] : wd;
      end
      default: r = old;
    endcase
    return r;
  endfunction

  // Misalignment or illegal encoding (range is checked separately).
  function automatic logic access_illegal(input logic [2:0] f3, input logic we,
                                          input logic [1:0] lo);
    logic e;
    case (f3)
      F3_B:    e = 1'b0;
      F3_H:    e = lo[0];
      F3_W:    e = (lo != 2'b00);
      F3_BU:   e = we;
      F3_HU:   e = we | lo[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Combinational lane logic between the DMEM read word and the core.
//   funct3_i     : latched access size/signedness
//   lane_i       : latched byte address bits [1:0]
//   rword_i      : word currently read from DMEM
//   wdata_i      : low 16 bits of the latched store data
//   load_data_o  : extracted and extended load result
//   store_word_o : read word with the store lane(s) replaced
// -----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  // Both views are computed every cycle; the FSM picks which one to register.
  always_comb begin
    load_data_o  = lane_extract(funct3_i, lane_i, rword_i);
    store_word_o = lane_merge(funct3_i, lane_i, rword_i, wdata_i);
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// -----------------------------------------------------------------------------
// lsu_dmem_master
// Core-side load/store initiator for a word-indexed DMEM (combinational read,
// posedge write). One request per handshake; sub-word stores are done as
// read-modify-write.
//   clk, rst_n                  : clock, async active-low reset
//   req_valid/req_ready         : request handshake (ready only in IDLE)
//   req_we/funct3/addr/wdata    : request fields, latched on accept
//   rsp_valid/rsp_ready         : response handshake, held under back-pressure
//   rsp_rdata/rsp_err           : load result (0 for stores/errors), error flag
//   dmem_addr/data_W/data_R     : DMEM word index, write word, read word
//   dmem_memwrite               : one-cycle write strobe, only in WR
// -----------------------------------------------------------------------------
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_data_W,
  input  logic [31:0]       dmem_data_R,
  output logic              dmem_memwrite
);

  logic [1:0]        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]       data_w_q, data_w_d;
  logic              memwrite_q, memwrite_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;

  logic [ADDR_W-1:0] req_word_s;
  logic              req_err_s;
  logic [31:0]       load_data_s;
  logic [31:0]       store_word_s;

  // Word index and error classification of the incoming request.
  always_comb begin
    req_word_s = {2'b00, req_addr[ADDR_W-1:2]};
    req_err_s  = access_illegal(req_funct3, req_we, req_addr[1:0]) |
                 (req_word_s >= ADDR_W'(DEPTH));
  end

  lsu_lane_align u_lane_align (
    .funct3_i     (funct3_q),
    .lane_i       (lane_q),
    .rword_i      (dmem_data_R),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data_s),
    .store_word_o (store_word_s)
  );

  // FSM next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    dmem_addr_d = dmem_addr_q;
    data_w_d    = data_w_q;
    memwrite_d  = 1'b0;
    we_d        = we_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          lane_d      = req_addr[1:0];
          wdata_d     = req_wdata[15:0];
          dmem_addr_d = req_word_s;
          rsp_rdata_d = 32'd0;
          req_ready_d = 1'b0;
          if (req_err_s) begin
            // Errors skip DMEM entirely and respond next cycle.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && (req_funct3 == F3_W)) begin
            // Full-word store needs no read.
            state_d    = ST_WR;
            data_w_d   = req_wdata;
            memwrite_d = 1'b1;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (we_q) begin
          state_d    = ST_WR;
          data_w_d   = store_word_s;
          memwrite_d = 1'b1;
        end else begin
          state_d     = ST_RESP;
          rsp_rdata_d = load_data_s;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      ST_WR: begin
        state_d     = ST_RESP;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset clears the write strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      dmem_addr_q <= '0;
      data_w_q    <= 32'd0;
      memwrite_q  <= 1'b0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      dmem_addr_q <= dmem_addr_d;
      data_w_q    <= data_w_d;
      memwrite_q  <= memwrite_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_data_W   = data_w_q;
  assign dmem_memwrite = memwrite_q;

endmodule
